// File: rtl/pulse_pkg.sv
// pulse_pkg: shared definitions for the multi-channel pulse generator.
//   - per-channel edge-select encodings
//   - debounce counter width helper
//   - edge/mode qualification helper
package pulse_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF  = 2'b00;
    localparam mode_t MODE_RISE = 2'b01;
    localparam mode_t MODE_FALL = 2'b10;
    localparam mode_t MODE_BOTH = 2'b11;

    // Width of a counter that must hold 0..n; never narrower than 1 bit.
    function automatic int db_cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // True when a level change towards new_lvl is selected by mode.
    function automatic logic edge_match(input mode_t mode, input logic new_lvl);
        if (new_lvl) return (mode == MODE_RISE) || (mode == MODE_BOTH);
        else         return (mode == MODE_FALL) || (mode == MODE_BOTH);
    endfunction

endpackage

// File: rtl/pulse_gen_multi_if.sv
// pulse_gen_multi_if: signal bundle between the raw-input side and the
// pulse generator.
//   in    [CH]        raw asynchronous inputs
//   mode  [2*CH]      per-channel edge select, channel i at [2i+1:2i]
//   clr               synchronous clear of event counters
//   out   [CH]        one-cycle pulse per qualified edge
//   level [CH]        debounced level
//   cnt   [CH*CNT_W]  event counts, channel i at [CNT_W*i +: CNT_W]
// master drives in/mode/clr, slave (the generator) drives out/level/cnt.
interface pulse_gen_multi_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
);
    logic [CH-1:0]       in;
    logic [2*CH-1:0]     mode;
    logic                clr;
    logic [CH-1:0]       out;
    logic [CH-1:0]       level;
    logic [CH*CNT_W-1:0] cnt;

    modport master (output in, mode, clr, input out, level, cnt);
    modport slave  (input in, mode, clr, output out, level, cnt);
endinterface

// File: rtl/pulse_chan.sv
// pulse_chan: one channel of the pulse generator.
//   2-flop synchroniser -> counter debouncer -> edge select -> 1-cycle pulse.
// Ports:
//   NewCLK, RST  clock / async active-low reset
//   raw          raw asynchronous input bit
//   mode         edge select (off / rise / fall / both)
//   clr          synchronous counter clear (counter build only)
//   out          registered pulse, high one cycle per qualified edge
//   level        debounced level
//   cnt          saturating pulse count (0 unless PULSE_COUNT_EN defined)
// Optional feature macro: PULSE_COUNT_EN.
module pulse_chan
    import pulse_pkg::*;
#(
    parameter int DB_CYCLES = 8,
    parameter int CNT_W     = 8
) (
    input  logic             NewCLK,
    input  logic             RST,
    input  logic             raw,
    input  mode_t            mode,
    input  logic             clr,
    output logic             out,
    output logic             level,
    output logic [CNT_W-1:0] cnt
);

    logic s1, s2;
    logic lvl_d;
    logic fire;

    generate
        if (DB_CYCLES == 0) begin : g_nodb
            always_comb begin
                lvl_d = s2;
            end
        end else begin : g_db
            localparam int DW = db_cnt_w(DB_CYCLES);
            logic [DW-1:0] dbc_q, dbc_d;

            // Counter runs only while s2 disagrees with level; any agreement
            // restarts it, so short glitches never reach the terminal count.
            always_comb begin
                dbc_d = dbc_q;
                lvl_d = level;
                if (s2 == level) begin
                    dbc_d = '0;
                end else if (dbc_q == DW'(DB_CYCLES - 1)) begin
                    lvl_d = s2;
                    dbc_d = '0;
                end else begin
                    dbc_d = dbc_q + DW'(1);
                end
            end

            always_ff @(posedge NewCLK or negedge RST) begin
                if (!RST) dbc_q <= '0;
                else      dbc_q <= dbc_d;
            end
        end
    endgenerate

    // Pulse is decided on the same edge that moves level.
    assign fire = (lvl_d != level) && edge_match(mode, lvl_d);

    always_ff @(posedge NewCLK or negedge RST) begin
        if (!RST) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            out   <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            level <= lvl_d;
            out   <= fire;
        end
    end

`ifdef PULSE_COUNT_EN
    // Counts on the pulse-setting edge so a coincident clr always wins.
    always_ff @(posedge NewCLK or negedge RST) begin
        if (!RST)                  cnt <= '0;
        else if (clr)              cnt <= '0;
        else if (fire && cnt != '1) cnt <= cnt + CNT_W'(1);
    end
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign cnt        = '0;
`endif

endmodule

// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi: CH independent debounced edge-pulse channels.
// Ports:
//   NewCLK  system clock, rising edge
//   RST     asynchronous active-low reset
//   bus     pulse_gen_multi_if.slave (in, mode, clr -> out, level, cnt)
// Optional feature macro: PULSE_COUNT_EN (per-channel saturating counters;
// when undefined cnt reads 0 and clr is ignored).
module pulse_gen_multi
    import pulse_pkg::*;
#(
    parameter int CH        = 4,
    parameter int DB_CYCLES = 8,
    parameter int CNT_W     = 8
) (
    input  logic               NewCLK,
    input  logic               RST,
    pulse_gen_multi_if.slave   bus
);

    logic [CH-1:0]            out_v;
    logic [CH-1:0]            level_v;
    logic [CH-1:0][CNT_W-1:0] cnt_v;

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            pulse_chan #(
                .DB_CYCLES (DB_CYCLES),
                .CNT_W     (CNT_W)
            ) u_chan (
                .NewCLK (NewCLK),
                .RST    (RST),
                .raw    (bus.in[i]),
                .mode   (bus.mode[2*i +: 2]),
                .clr    (bus.clr),
                .out    (out_v[i]),
                .level  (level_v[i]),
                .cnt    (cnt_v[i])
            );
        end
    endgenerate

    assign bus.out   = out_v;
    assign bus.level = level_v;
    assign bus.cnt   = cnt_v;

endmodule

// File: tb/tb_pulse_gen_multi.sv
// tb_pulse_gen_multi: directed bench for pulse_gen_multi.
//   dut  : CH=4, DB_CYCLES=8, CNT_W=2 (table of hold segments + hand sequences)
//   dut0 : CH=1, DB_CYCLES=0 (bypassed debounce)
// Counter checks adapt to PULSE_COUNT_EN.
module tb_pulse_gen_multi;

    logic NewCLK = 1'b0;
    logic RST;
    int   total = 0;
    int   bad   = 0;

    always #5 NewCLK = ~NewCLK;

    pulse_gen_multi_if #(.CH(4), .CNT_W(2)) bus  ();
    pulse_gen_multi_if #(.CH(1), .CNT_W(2)) bus0 ();

    pulse_gen_multi #(.CH(4), .DB_CYCLES(8), .CNT_W(2)) dut (
        .NewCLK (NewCLK),
        .RST    (RST),
        .bus    (bus)
    );

    pulse_gen_multi #(.CH(1), .DB_CYCLES(0), .CNT_W(2)) dut0 (
        .NewCLK (NewCLK),
        .RST    (RST),
        .bus    (bus0)
    );

    typedef struct {
        logic [3:0] in;
        logic [7:0] mode;
        int         n;      // cycles to hold
        logic [3:0] mask;   // channels expected to pulse
        int         at;     // cycle index of the pulse (1 = after E0), 0 = none
        logic [3:0] lvl;    // level at end of segment
    } vec_t;

    localparam int NV = 13;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge NewCLK);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Pulse for a change first sampled at E0 appears after E9 (k=10).
        tbl[0]  = '{4'b0001, 8'h55, 20, 4'b0001, 10, 4'b0001}; // ch0 rise
        tbl[1]  = '{4'b0011, 8'h55,  7, 4'b0000,  0, 4'b0001}; // ch1 7-cycle glitch
        tbl[2]  = '{4'b0001, 8'h55, 12, 4'b0000,  0, 4'b0001};
        tbl[3]  = '{4'b0011, 8'h55, 12, 4'b0010, 10, 4'b0011}; // ch1 real rise
        tbl[4]  = '{4'b0111, 8'h75, 12, 4'b0100, 10, 4'b0111}; // ch2 both: rise
        tbl[5]  = '{4'b0011, 8'h75, 12, 4'b0100, 10, 4'b0011}; // ch2 both: fall
        tbl[6]  = '{4'b0111, 8'h65, 12, 4'b0000,  0, 4'b0111}; // ch2 fall-only: rise
        tbl[7]  = '{4'b0011, 8'h65, 12, 4'b0100, 10, 4'b0011}; // ch2 fall-only: fall
        tbl[8]  = '{4'b1011, 8'h55,  8, 4'b0000,  0, 4'b0011}; // ch3 exactly 8 high
        tbl[9]  = '{4'b0011, 8'h55, 12, 4'b1000,  2, 4'b0011}; // ...pulse lands here
        tbl[10] = '{4'b0000, 8'h00, 12, 4'b0000,  0, 4'b0000}; // off: level tracked
        tbl[11] = '{4'b1111, 8'h55, 12, 4'b1111, 10, 4'b1111}; // all rise together
        tbl[12] = '{4'b0000, 8'hAA, 12, 4'b1111, 10, 4'b0000}; // all fall together

        RST       = 1'b0;
        bus.in    = '0;
        bus.mode  = '0;
        bus.clr   = 1'b0;
        bus0.in   = '0;
        bus0.mode = '0;
        bus0.clr  = 1'b0;

        repeat (2) step();
        chk("rst_out",    32'(bus.out),    32'h0);
        chk("rst_level",  32'(bus.level),  32'h0);
        chk("rst_cnt",    32'(bus.cnt),    32'h0);
        chk("rst_out0",   32'(bus0.out),   32'h0);
        chk("rst_level0", 32'(bus0.level), 32'h0);
        RST = 1'b1;

        for (int v = 0; v < NV; v++) begin
            bus.in   = tbl[v].in;
            bus.mode = tbl[v].mode;
            for (int k = 1; k <= tbl[v].n; k++) begin
                step();
                chk($sformatf("v%0d_k%0d_out", v, k), 32'(bus.out),
                    (k == tbl[v].at) ? 32'(tbl[v].mask) : 32'h0);
            end
            chk($sformatf("v%0d_level", v), 32'(bus.level), 32'(tbl[v].lvl));
        end

        // Async reset mid-operation, then rise on ch3 held through release.
        bus.in   = 4'hF;
        bus.mode = 8'h55;
        run(12);
        chk("pre_rst_level", 32'(bus.level), 32'hF);
        bus.in = 4'h1;
        run(4);                 // ch0 mid-debounce of its fall
        @(posedge NewCLK);
        #3 RST = 1'b0;
        #1;
        chk("async_rst_out",   32'(bus.out),   32'h0);
        chk("async_rst_level", 32'(bus.level), 32'h0);
        chk("async_rst_cnt",   32'(bus.cnt),   32'h0);
        bus.in = 4'h8;
        repeat (2) @(posedge NewCLK);
        #2 RST = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("post_rst_k%0d_out", k), 32'(bus.out),
                (k == 10) ? 32'h8 : 32'h0);
        end
        chk("post_rst_level", 32'(bus.level), 32'h8);

        // Event counters on ch0.
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        chk("clr_cnt0", 32'(bus.cnt[1:0]), 32'h0);
        for (int p = 1; p <= 5; p++) begin
            bus.in = 4'h9;
            run(12);
            bus.in = 4'h8;
            run(12);
`ifdef PULSE_COUNT_EN
            chk($sformatf("cnt0_p%0d", p), 32'(bus.cnt[1:0]), (p > 3) ? 32'h3 : 32'(p));
`else
            chk($sformatf("cnt_tied_p%0d", p), 32'(bus.cnt), 32'h0);
`endif
        end
        bus.in = 4'h9;
        run(9);
        bus.clr = 1'b1;         // sampled on the pulse edge
        step();
        bus.clr = 1'b0;
        chk("clr_pulse_out0", 32'(bus.out[0]), 32'h1);
        chk("clr_pulse_cnt0", 32'(bus.cnt[1:0]), 32'h0);
        run(3);
        chk("clr_after_cnt0", 32'(bus.cnt[1:0]), 32'h0);

        // Bypassed debounce: pulse and level change at E2 (k=3) per toggle.
        begin
            logic prev;
            logic val;
            prev       = 1'b0;
            bus0.mode  = 2'b11;
            for (int t = 0; t < 4; t++) begin
                val     = ~prev;
                bus0.in = val;
                for (int k = 1; k <= 3; k++) begin
                    step();
                    chk($sformatf("db0_t%0d_k%0d_out", t, k), 32'(bus0.out),
                        (k == 3) ? 32'h1 : 32'h0);
                    chk($sformatf("db0_t%0d_k%0d_lvl", t, k), 32'(bus0.level),
                        (k == 3) ? 32'(val) : 32'(prev));
                end
                prev = val;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
